// File: rtl/mult_sweep_ctrl.sv
// mult_sweep_ctrl: exhaustive operand sweep and error characterizer for an
// external signed W x W approximate multiplier. Drives every (a, b) pair with
// b as the outer loop and a as the inner loop. Each returned product is
// compared against the exact signed product. Error count, signed sum,
// absolute sum and maximum absolute error are accumulated over the sweep.
module mult_sweep_ctrl #(
  parameter int W     = 8,
  parameter int ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    hold,
  output logic [W-1:0]            a_o,
  output logic [W-1:0]            b_o,
  input  logic [2*W-1:0]          p_i,
  output logic                    busy,
  output logic                    done,
  output logic [2*W:0]            err_count,
  output logic signed [ACC_W-1:0] err_sum,
  output logic [ACC_W-1:0]        abs_err_sum,
  output logic [2*W:0]            max_abs_err
);

  // Error width: a 2W-bit product difference needs one extra bit.
  localparam int EW = 2*W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Exact signed W x W product, widened to the error width.
  function automatic logic signed [EW-1:0] exact_prod(input logic [W-1:0] a,
                                                      input logic [W-1:0] b);
    logic signed [2*W-1:0] ax;
    logic signed [2*W-1:0] bx;
    logic signed [2*W-1:0] p;
    ax = {{W{a[W-1]}}, a};
    bx = {{W{b[W-1]}}, b};
    p  = ax * bx;
    return {p[2*W-1], p};
  endfunction

  // Sign-extend the 2W-bit approximate product to the error width.
  function automatic logic signed [EW-1:0] sext_prod(input logic [2*W-1:0] p);
    return {p[2*W-1], p};
  endfunction

  // Magnitude of an error. Unsigned EW bits hold the full range, including
  // the most negative value, so no saturation is needed.
  function automatic logic [EW-1:0] abs_err(input logic signed [EW-1:0] e);
    logic [EW-1:0] u;
    u = e;
    return e[EW-1] ? (~u + {{(EW-1){1'b0}}, 1'b1}) : u;
  endfunction

  state_t                  state_q, state_d;
  logic [W-1:0]            a_q, a_d;
  logic [W-1:0]            b_q, b_d;
  logic                    vld_p1, vld_d;
  logic signed [EW-1:0]    e_p1, e_d;
  logic [EW-1:0]           cnt_q, cnt_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic [ACC_W-1:0]        asum_q, asum_d;
  logic [EW-1:0]           max_q, max_d;

  logic signed [EW-1:0]    err_p0;
  logic [EW-1:0]           abs_p1;
  logic                    last_pair;

  // Stage 0: error of the pair currently presented to the multiplier
  assign err_p0    = sext_prod(p_i) - exact_prod(a_q, b_q);
  assign last_pair = (a_q == {W{1'b1}}) && (b_q == {W{1'b1}});

  // Stage 1: magnitude of the registered error, feeding the accumulators
  assign abs_p1 = abs_err(e_p1);

  // Next-state, operand stepping, stage-1 capture and accumulation
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    vld_d   = 1'b0;
    e_d     = e_p1;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    asum_d  = asum_q;
    max_d   = max_q;

    if (vld_p1) begin
      sum_d  = sum_q + {{(ACC_W-EW){e_p1[EW-1]}}, e_p1};
      asum_d = asum_q + {{(ACC_W-EW){1'b0}}, abs_p1};
      cnt_d  = cnt_q + {{(EW-1){1'b0}}, (e_p1 != '0)};
      if (abs_p1 > max_q) max_d = abs_p1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = '0;
          b_d     = '0;
          cnt_d   = '0;
          sum_d   = '0;
          asum_d  = '0;
          max_d   = '0;
        end
      end
      S_RUN: begin
        if (!hold) begin
          vld_d = 1'b1;
          e_d   = err_p0;
          if (last_pair) begin
            // Operands park at all-ones while the last entry drains.
            state_d = S_DRAIN;
          end else begin
            a_d = a_q + {{(W-1){1'b0}}, 1'b1};
            if (a_q == {W{1'b1}}) b_d = b_q + {{(W-1){1'b0}}, 1'b1};
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and statistics registers; reset wins over every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      vld_p1  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      asum_q  <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      vld_p1  <= vld_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      asum_q  <= asum_d;
      max_q   <= max_d;
    end
  end

  // Stage-1 error datapath register, qualified by vld_p1
  always_ff @(posedge clk) begin
    e_p1 <= e_d;
  end

  assign a_o         = a_q;
  assign b_o         = b_q;
  assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);
  assign err_count   = cnt_q;
  assign err_sum     = sum_q;
  assign abs_err_sum = asum_q;
  assign max_abs_err = max_q;

endmodule

// File: doc/mult_sweep_ctrl.md
Name: mult_sweep_ctrl

Overview:
Sequencer and error characterizer for one signed W×W approximate multiplier under evaluation. It drives every operand pair in a fixed order into the external multiplier's combinational inputs and samples the approximate product. It compares each product with an internally computed exact signed product and accumulates error statistics. It replaces software sweeps and allows on-chip characterization of any multiplier variant with the same a/b/p interface.

Parameters:
W, 8, operand width. The sweep covers 2^(2W) pairs.
ACC_W, 40, width of the signed error-sum and absolute-error-sum accumulators.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin sweep. Honoured only in IDLE or DONE.
hold  in  1  stall the sweep while high. Operands freeze and no sample is taken.
a_o  out  W  operand a to the multiplier, registered
b_o  out  W  operand b to the multiplier, registered
p_i  in  2W  approximate product, signed, combinational function of a_o/b_o
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE; held until the next start or rst
err_count  out  2W+1  number of pairs with a nonzero error
err_sum  out  ACC_W  signed sum of (p_i − exact)
abs_err_sum  out  ACC_W  sum of |p_i − exact|
max_abs_err  out  2W+1  maximum of |p_i − exact|

Behaviour:
- Reset: on a clk edge with rst=1, all of the following are forced to 0 and the state goes to IDLE: a_o, b_o, busy, done, err_count, err_sum, abs_err_sum, max_abs_err, and the stage-1 valid flag. rst has priority over every other input, including mid-sweep.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE → RUN on start=1:
  - a_o and b_o go to 0.
  - All statistics are cleared.
  - done goes to 0 and busy goes to 1.
- RUN, hold=0, each edge:
  - The pair (a_o, b_o, p_i) is sampled into stage 1.
  - The error is computed as e = $signed(p_i) − $signed(a_o)·$signed(b_o), sign-extended to 2W+1 bits. It is registered together with valid=1.
  - The operands then advance. a_o increments; on wrap from 2^W−1 to 0, b_o increments. Order: b is the outer loop, a the inner loop, both starting from raw pattern 0.
- RUN, hold=1: operands hold and stage-1 valid is 0. Statistics are unchanged except for absorbing any already-valid stage-1 entry.
- RUN → DRAIN: on the edge that samples the pair a_o=b_o=2^W−1. Operands then hold at all-ones.
- DRAIN → DONE: on the next edge. The final stage-1 entry is accumulated on this same edge, so done and the final statistics become visible together. hold is ignored in DRAIN.
- Accumulation, on each edge with stage-1 valid=1:
  - err_sum += e.
  - abs_err_sum += |e|.
  - err_count += (e≠0).
  - max_abs_err = max(max_abs_err, |e|).
  - Accumulators never saturate. With the defaults they cannot overflow.
- Latency: done rises exactly 2^(2W)+1 edges after the start-accepting edge, plus one edge per cycle with hold=1 in RUN. For W=8 this is 65537 edges.
- start while busy=1 is ignored. start in DONE restarts the sweep and clears the statistics.
- Statistics outputs are stable while in IDLE and DONE.

Test Plan:
1. Exact stub (p_i = a_o·b_o, signed), start pulse. Required response:
   - busy rises next cycle.
   - done rises 65537 edges after start.
   - err_count=0, err_sum=0, abs_err_sum=0, max_abs_err=0.
2. Stub p_i = exact+1. Required response: err_count=65536, err_sum=+65536, abs_err_sum=65536, max_abs_err=1.
3. Stub p_i = exact with bit 0 cleared. Only odd×odd pairs are affected (16384 pairs). Required response: err_count=16384, err_sum=−16384, abs_err_sum=16384, max_abs_err=1.
4. Scenario 3 with hold toggling 1/0 every cycle throughout RUN. Required response:
   - Statistics identical to scenario 3.
   - done delayed by exactly the number of hold=1 cycles in RUN.
   - a_o/b_o never skip or repeat a sampled pair.
5. rst=1 while in RUN with b_o=3, a_o=232. Required response:
   - Next cycle all outputs are 0 and the state is IDLE.
   - A following start reproduces scenario 3 results exactly.
6. start asserted at random cycles while busy=1 → no effect on the sweep or the statistics. start in DONE → done drops, statistics clear, and a full sweep re-runs.
